// File: rtl/throttle_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : throttle_sched_if
//  Description : Bundle of the per-queue request signals and the downstream
//                grant handshake shared by the throttling scheduler and its
//                surroundings.
//                master : traffic side (drives config, requests, grant_ready)
//                slave  : scheduler side (drives req_ready and the grant)
//  Revision    : 1.0 - initial release
// ============================================================================
interface throttle_sched_if #(
    parameter int NUM_Q  = 4,
    parameter int LOG2_Q = 2
);
    logic [NUM_Q*8-1:0] cfg_perc;     // per-queue issue percentage
    logic [NUM_Q-1:0]   req_valid;    // queue has a pending request
    logic [NUM_Q*4-1:0] req_len;      // per-queue request length
    logic [NUM_Q-1:0]   req_ready;    // one-hot pop pulse
    logic               grant_valid;  // grant held toward downstream
    logic [LOG2_Q-1:0]  grant_id;     // queue index of held grant
    logic [3:0]         grant_len;    // length of held grant
    logic               grant_ready;  // downstream accepts grant

    modport master (
        output cfg_perc, req_valid, req_len, grant_ready,
        input  req_ready, grant_valid, grant_id, grant_len
    );

    modport slave (
        input  cfg_perc, req_valid, req_len, grant_ready,
        output req_ready, grant_valid, grant_id, grant_len
    );
endinterface
`default_nettype wire

// File: rtl/throttle_sched.sv
`default_nettype none
// ============================================================================
//  Module      : throttle_sched
//  Description : Shares one downstream request port between NUM_Q queues.
//                Each queue is rate-limited by a Bresenham-style credit
//                accumulator; eligible queues are picked round-robin and the
//                winner is presented on a registered valid/ready grant port.
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-low reset
//                bus   - throttle_sched_if.slave (config, requests, grant)
//  Revision    : 1.0 - initial release
// ============================================================================
module throttle_sched #(
    parameter int NUM_Q  = 4,
    parameter int LOG2_Q = 2,
    parameter int CENTER = 1000,
    parameter int DX     = 100
) (
    input  logic             clk,
    input  logic             reset,
    throttle_sched_if.slave  bus
);

    localparam logic [0:0]      C_IDLE   = 1'b0;
    localparam logic [0:0]      C_HOLD   = 1'b1;
    localparam logic [15:0]     C_CENTER = 16'(CENTER);
    localparam logic [15:0]     C_INIT   = 16'(CENTER - DX);
    localparam logic [7:0]      C_DX8    = 8'(DX);
    localparam logic [20:0]     C_TWO_DX = 21'(2 * DX);
    localparam logic [LOG2_Q:0] C_NQ     = (LOG2_Q + 1)'(NUM_Q);

    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic [LOG2_Q-1:0] r_rr_ptr;
    logic [LOG2_Q-1:0] r_grant_id;
    logic [3:0]        r_grant_len;
    logic [NUM_Q-1:0]  r_req_ready;
    logic [15:0]       r_d      [NUM_Q];
    logic [15:0]       w_d_next [NUM_Q];

    logic [7:0]        w_p       [NUM_Q];
    logic [8:0]        w_two_p   [NUM_Q];
    logic [3:0]        w_len_eff [NUM_Q];
    logic [16:0]       w_acc     [NUM_Q];
    logic [NUM_Q-1:0]  w_elig;

    logic              w_load;
    logic              w_found;
    logic              w_sel;
    logic [LOG2_Q-1:0] w_win;
    logic [LOG2_Q:0]   w_idx;
    logic signed [20:0] w_step;
    logic signed [20:0] w_prod;
    logic signed [20:0] w_sum;
    logic [15:0]       w_debit_d;

    // Per-queue decode: clamped percentage, effective length, eligibility
    // and the saturating credit accrual candidate.
    generate
        for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_queue
            assign w_p[gi]       = (bus.cfg_perc[8*gi +: 8] > C_DX8) ? C_DX8
                                                                     : bus.cfg_perc[8*gi +: 8];
            assign w_two_p[gi]   = {w_p[gi], 1'b0};
            assign w_len_eff[gi] = (bus.req_len[4*gi +: 4] == 4'd0) ? 4'd1
                                                                    : bus.req_len[4*gi +: 4];
            assign w_acc[gi]     = {1'b0, r_d[gi]} + {8'd0, w_two_p[gi]};
            assign w_elig[gi]    = bus.req_valid[gi] && (r_d[gi] > C_CENTER);
        end
    endgenerate

    assign w_load = (r_state == C_IDLE) || bus.grant_ready;

    // Round-robin search starting just above the last winner.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_Q; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (LOG2_Q + 1)'(k);
            if (w_idx >= C_NQ) begin
                w_idx = w_idx - C_NQ;
            end
            if (!w_found && w_elig[w_idx[LOG2_Q-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[LOG2_Q-1:0];
            end
        end
    end

    assign w_sel = w_load && w_found;

    // Winner debit: (2p - 2*DX) * len is never positive, but both rails are
    // clamped so the accumulator can never wrap.
    always_comb begin
        w_step    = $signed({12'd0, w_two_p[w_win]}) - $signed(C_TWO_DX);
        w_prod    = w_step * $signed({17'd0, w_len_eff[w_win]});
        w_sum     = $signed({5'd0, r_d[w_win]}) + w_prod;
        w_debit_d = w_sum[15:0];
        if (w_sum < 21'sd0) begin
            w_debit_d = 16'd0;
        end else if (w_sum > 21'sd65535) begin
            w_debit_d = 16'hFFFF;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_Q; i++) begin
            w_d_next[i] = r_d[i];
            if (w_sel && (LOG2_Q'(i) == w_win)) begin
                w_d_next[i] = w_debit_d;
            end else if (bus.req_valid[i] && !w_elig[i]) begin
                w_d_next[i] = w_acc[i][16] ? 16'hFFFF : w_acc[i][15:0];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_IDLE:  if (w_sel) w_state_next = C_HOLD;
            C_HOLD:  if (bus.grant_ready && !w_sel) w_state_next = C_IDLE;
            default: w_state_next = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= C_IDLE;
            r_rr_ptr    <= LOG2_Q'(NUM_Q - 1);
            r_grant_id  <= '0;
            r_grant_len <= '0;
            r_req_ready <= '0;
            for (int i = 0; i < NUM_Q; i++) begin
                r_d[i] <= C_INIT;
            end
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= w_sel ? (NUM_Q'(1) << w_win) : '0;
            if (w_sel) begin
                r_rr_ptr    <= w_win;
                r_grant_id  <= w_win;
                r_grant_len <= w_len_eff[w_win];
            end
            for (int i = 0; i < NUM_Q; i++) begin
                r_d[i] <= w_d_next[i];
            end
        end
    end

    assign bus.grant_valid = (r_state == C_HOLD);
    assign bus.grant_id    = r_grant_id;
    assign bus.grant_len   = r_grant_len;
    assign bus.req_ready   = r_req_ready;

endmodule
`default_nettype wire

// File: tb/tb_throttle_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_throttle_sched
//  Description : Self-checking bench for throttle_sched. Directed scenarios
//                followed by random traffic, all compared each cycle against
//                an integer reference model of the credit/round-robin rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_throttle_sched;

    localparam int NQ = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    throttle_sched_if #(.NUM_Q(NQ), .LOG2_Q(2)) bus ();

    throttle_sched #(
        .NUM_Q (NQ),
        .LOG2_Q(2),
        .CENTER(1000),
        .DX    (100)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Stimulus state
    int perc  [NQ];
    int len   [NQ];
    bit valid [NQ];
    bit gr;

    // Reference model state
    int m_d [NQ];
    int m_rr;
    bit m_gv;
    int m_id;
    int m_len;
    int m_rdy;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NQ; i++) m_d[i] = 900;
        m_rr  = NQ - 1;
        m_gv  = 1'b0;
        m_id  = 0;
        m_len = 0;
        m_rdy = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < NQ; i++) begin
            bus.cfg_perc[8*i +: 8] = 8'(perc[i]);
            bus.req_len[4*i +: 4]  = 4'(len[i]);
            bus.req_valid[i]       = valid[i];
        end
        bus.grant_ready = gr;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NQ; i++) begin
            perc[i]  = 0;
            len[i]   = 0;
            valid[i] = 1'b0;
        end
        gr = 1'b0;
    endtask

    task automatic check_all(string tag);
        chk($sformatf("%s grant_valid", tag), 32'(bus.grant_valid), 32'(m_gv));
        chk($sformatf("%s grant_id", tag),    32'(bus.grant_id),    32'(m_id));
        chk($sformatf("%s grant_len", tag),   32'(bus.grant_len),   32'(m_len));
        chk($sformatf("%s req_ready", tag),   32'(bus.req_ready),   32'(m_rdy));
        chk($sformatf("%s d0", tag), 32'(dut.r_d[0]), 32'(m_d[0]));
        chk($sformatf("%s d1", tag), 32'(dut.r_d[1]), 32'(m_d[1]));
        chk($sformatf("%s d2", tag), 32'(dut.r_d[2]), 32'(m_d[2]));
        chk($sformatf("%s d3", tag), 32'(dut.r_d[3]), 32'(m_d[3]));
    endtask

    // One clock: predict the post-edge state from the pre-edge state and the
    // current inputs, then compare shortly after the edge.
    task automatic step(string tag);
        bit el [NQ];
        int nd [NQ];
        bit load;
        int win;
        int p;
        int le;
        drive();
        load = !m_gv || gr;
        win  = -1;
        for (int i = 0; i < NQ; i++) el[i] = valid[i] && (m_d[i] > 1000);
        if (load) begin
            for (int k = 1; k <= NQ; k++) begin
                if (win < 0 && el[(m_rr + k) % NQ]) win = (m_rr + k) % NQ;
            end
        end
        for (int i = 0; i < NQ; i++) begin
            p     = (perc[i] > 100) ? 100 : perc[i];
            le    = (len[i] == 0) ? 1 : len[i];
            nd[i] = m_d[i];
            if (i == win) begin
                nd[i] = m_d[i] + (2 * p - 200) * le;
                if (nd[i] < 0) nd[i] = 0;
                if (nd[i] > 65535) nd[i] = 65535;
            end else if (valid[i] && !el[i]) begin
                nd[i] = m_d[i] + 2 * p;
                if (nd[i] > 65535) nd[i] = 65535;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NQ; i++) m_d[i] = nd[i];
        if (win >= 0) begin
            m_gv  = 1'b1;
            m_id  = win;
            m_len = (len[win] == 0) ? 1 : len[win];
            m_rdy = 1 << win;
            m_rr  = win;
        end else begin
            m_rdy = 0;
            if (load) m_gv = 1'b0;
        end
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        drive();

        // Queue 0 only, full rate, single-beat requests
        do_reset();
        perc[0] = 100; len[0] = 1; valid[0] = 1'b1; gr = 1'b1;
        step("p100 e1");
        chk("p100 no grant edge1", 32'(bus.grant_valid), 32'd0);
        step("p100 e2");
        chk("p100 grant edge2", 32'(bus.grant_valid), 32'd1);
        repeat (6) step("p100");

        // Queue 0 only, half rate
        do_reset();
        perc[0] = 50; len[0] = 1; valid[0] = 1'b1; gr = 1'b1;
        repeat (10) step("p50");

        // Two queues alternating
        do_reset();
        perc[0] = 100; perc[1] = 100; len[0] = 2; len[1] = 3;
        valid[0] = 1'b1; valid[1] = 1'b1; gr = 1'b1;
        repeat (8) step("alt");

        // Stall with grant_ready low, then release
        do_reset();
        perc[0] = 100; len[0] = 5; valid[0] = 1'b1; gr = 1'b1;
        repeat (2) step("stall pre");
        gr = 1'b0;
        repeat (5) step("stall hold");
        gr = 1'b1;
        repeat (3) step("stall rel");

        // Clamp and saturation: perc 0, perc >100, tiny perc with long length
        do_reset();
        perc[0] = 1;   len[0] = 15; valid[0] = 1'b1;
        perc[1] = 200; len[1] = 1;  valid[1] = 1'b1;
        perc[2] = 0;   len[2] = 4;  valid[2] = 1'b1;
        gr = 1'b1;
        repeat (60) step("clamp");
        chk("perc0 d stays", 32'(dut.r_d[2]), 32'd900);

        // Random traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NQ; i++) begin
                if ($urandom_range(0, 7) == 0) perc[i] = $urandom_range(0, 255);
                else if ($urandom_range(0, 3) == 0) perc[i] = $urandom_range(0, 110);
                len[i]   = $urandom_range(0, 15);
                valid[i] = ($urandom_range(0, 3) != 0);
            end
            gr = ($urandom_range(0, 9) < 7);
            step("rand");
        end

        // Asynchronous reset while a grant is held
        do_reset();
        perc[0] = 100; len[0] = 7; valid[0] = 1'b1; gr = 1'b0;
        repeat (3) step("mid pre");
        chk("mid grant held", 32'(bus.grant_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async reset");
        clear_inputs();
        drive();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NQ; i++) begin
            perc[i] = 100; len[i] = 1; valid[i] = 1'b1;
        end
        gr = 1'b1;
        repeat (2) step("post reset");
        chk("post reset first id", 32'(bus.grant_id), 32'd0);
        repeat (4) step("post reset rr");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
